// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch controller feeding a UART transmitter, one byte per tx_start/tx_done.
// Optional sticky overflow flag is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [7:0]          wr_data_i,
    input  logic                flush_i,
    output logic                full_o,
    output logic                almost_full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                busy_o,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_i,
    input  logic                ovf_clr_i,
    output logic                ovf_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    localparam ptr_t PtrOne = ptr_t'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e     state_q, state_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] mem_q [Depth];

    logic empty;
    logic full;
    logic push;
    logic pop;
    ptr_t level;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
        level = wr_ptr_q - rd_ptr_q;
        push  = wr_en_i && !full && !flush_i;
        pop   = (state_q == StIdle) && !empty && !flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                    state_d   = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage needs no reset; only slots behind the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en_i && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_o          = 1'b0;
`endif

    assign empty_o       = empty;
    assign full_o        = full;
    assign level_o       = level;
    assign almost_full_o = (32'(level) >= AFULL_LEVEL);
    assign busy_o        = (state_q != StIdle);
    assign tx_start_o    = (state_q == StStart);
    assign tx_data_o     = tx_data_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the bus-side register interface into a power-of-two FIFO. It hands them one at a time to the transmitter with a single-cycle `tx_start` strobe and waits for the transmitter's `tx_done` pulse before launching the next byte. Software can therefore queue a burst of characters without polling per byte.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default); legal range 2..8.
- `AFULL_LEVEL`, default 12: `almost_full` asserts when `level >= AFULL_LEVEL`.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; pushes `wr_data` when the FIFO is not full.
- `wr_data`  in  8  byte to queue.
- `flush`  in  1  synchronous clear of queued (not yet launched) bytes.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `almost_full`  out  1  `level >= AFULL_LEVEL`.
- `empty`  out  1  FIFO holds 0 bytes.
- `level`  out  DEPTH_LOG2+1  number of queued bytes, 0..2^DEPTH_LOG2.
- `busy`  out  1  a byte is launched and not yet acknowledged by `tx_done`.
- `tx_start`  out  1  one-cycle launch strobe to the transmitter.
- `tx_data`  out  8  byte being transmitted; stable from `tx_start` until `tx_done`.
- `tx_done`  in  1  one-cycle completion pulse from the transmitter.
- `ovf_clr`  in  1  clears `ovf` (see Configuration).
- `ovf`  out  1  sticky overflow flag (see Configuration).

## Operation
- Storage is a 2^DEPTH_LOG2 x 8 register array.
- Pointers are DEPTH_LOG2+1 bits wide. The MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `level` = `wr_ptr - rd_ptr`, taken modulo 2^(DEPTH_LOG2+1).
- Push: accepted iff `wr_en && !full`, evaluated on registered `full`. A write presented while full is dropped and the stored data is unchanged.
- Controller FSM with three states:
  - IDLE: if `!empty`, pop the head into `tx_data`, set `tx_start`=1, and go to START.
  - START: `tx_start`=0; go to WAIT.
  - WAIT: on `tx_done`=1, go to IDLE; otherwise stay.
- `busy` = state is START or WAIT.
- `tx_done` is ignored in IDLE and START.
- Simultaneous push and pop: both take effect; `level` is unchanged. A push into an empty FIFO cannot be popped in the same cycle. It is popped on the following edge.
- `flush`:
  - Sets `rd_ptr` to `wr_ptr`, so `level` becomes 0.
  - A push in the same cycle is discarded.
  - An in-flight byte (START/WAIT) is not aborted; the FSM still waits for `tx_done`.
  - A pop in the same cycle is suppressed.
- Reset mid-transfer: the FSM returns to IDLE and the FIFO empties. The transmitter's own reset is responsible for the line.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=8'h00, `busy`=0
  - `empty`=1, `full`=0, `almost_full`=0 (1 if `AFULL_LEVEL`=0)
  - `level`=0, `ovf`=0
- All outputs are registered or decoded from registered pointers and state; there are no combinational paths from inputs to outputs.
- A write at edge N makes `empty`=0 and `level`=1 after edge N.
- The pop occurs at edge N+1. `tx_start` is high for exactly the cycle between edges N+1 and N+2.
- `tx_done` sampled high at edge D returns the FSM to IDLE at D. The next pop and `tx_start` occur at edge D+1. The minimum inter-byte gap is one clock.
- Per byte, `tx_start` pulses at most once and never while `busy` is already 1.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `ovf` is set on any `wr_en` while `full`.
  - `ovf` is cleared by `ovf_clr`.
  - If set and clear happen in the same cycle, set wins.
  - `ovf` is cleared by `rst`; `flush` does not affect it.
- Not defined: `ovf` is tied to 0, `ovf_clr` is ignored, and no overflow logic is synthesized. Dropped-write behaviour is identical in both builds.

## Test plan
- Single byte: write 8'hA5 into an empty FIFO with `tx_done` driven 40 cycles after `tx_start`. Required: `tx_start` for exactly one cycle, two edges after the write; `tx_data`=8'hA5 held until `tx_done`; `busy` falls at `tx_done`; `level` 1 -> 0 at the pop.
- Burst ordering: write 8'h01..8'h10 back-to-back (16 bytes, `DEPTH_LOG2`=4). Required:
  - `full`=1 after the 16th write (before the first pop) or after the 17th accepted push.
  - Bytes launch in order 8'h01..8'h10, each `tx_start` exactly one cycle after the prior `tx_done`.
- Overflow, with `UART_TX_FIFO_OVF_EN`: fill to 16 with the transmitter stalled (no `tx_done`), then write 8'hFF. Required: `level` stays 16, 8'hFF is never transmitted, `ovf`=1; pulse `ovf_clr` and `ovf`=0. Without the macro: `ovf` stays 0.
- Flush mid-transfer: queue 5 bytes; after the first `tx_start`, assert `flush` together with `wr_en`. Required: `level`=0 and `empty`=1 next cycle; the in-flight byte completes on `tx_done`; no further `tx_start`.
- Wrap-around: write and drain 40 bytes with interleaved single writes and pops. Required: no lost or duplicated bytes; `level` correct across pointer wrap.
- Reset in WAIT: assert `rst` while `busy`=1 with 3 bytes queued. Required: immediate `busy`=0, `tx_start`=0, `empty`=1, `level`=0; after release, no `tx_start` until a new write.
